// File: rtl/arrow_draw_scheduler_pkg.sv
// Shared constants, lane ordering and FSM encoding for the arrow draw scheduler slice.
package arrow_draw_scheduler_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;
  localparam int SPRITE_DIM = 8;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int COL_W      = 3;

  localparam logic [LANE_IDX_W-1:0] LANE_LEFT  = 2'd0;
  localparam logic [LANE_IDX_W-1:0] LANE_DOWN  = 2'd1;
  localparam logic [LANE_IDX_W-1:0] LANE_UP    = 2'd2;
  localparam logic [LANE_IDX_W-1:0] LANE_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_START,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_FINISH
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_IDX_W-1:0] idx);
    logic [NUM_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arrow_draw_scheduler_if.sv
// Drawer control/pixel bus plus the muxed VGA write port; master = scheduler, slave = drawers + adapter.
interface arrow_draw_scheduler_if;
  import arrow_draw_scheduler_pkg::*;

  logic [NUM_LANES-1:0]       drw_start;
  logic [X_W-1:0]             drw_refX;
  logic [Y_W-1:0]             drw_refY;
  logic [NUM_LANES-1:0]       drw_done;
  logic [NUM_LANES*X_W-1:0]   drw_x;
  logic [NUM_LANES*Y_W-1:0]   drw_y;
  logic [NUM_LANES*COL_W-1:0] drw_colour;
  logic [NUM_LANES-1:0]       drw_wen;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [COL_W-1:0]           colour;
  logic                       writeEn;

  modport master (
    output drw_start, drw_refX, drw_refY, x, y, colour, writeEn,
    input  drw_done, drw_x, drw_y, drw_colour, drw_wen
  );

  modport slave (
    input  drw_start, drw_refX, drw_refY, x, y, colour, writeEn,
    output drw_done, drw_x, drw_y, drw_colour, drw_wen
  );

endinterface

// File: rtl/arrow_draw_scheduler_pixel_mux4.sv
// 4:1 selection of one drawer's pixel stream by lane index; all-zero when not enabled.
module arrow_draw_scheduler_pixel_mux4
  import arrow_draw_scheduler_pkg::*;
(
  input  logic                       en_i,
  input  logic [LANE_IDX_W-1:0]      idx_i,
  input  logic [NUM_LANES*X_W-1:0]   x_i,
  input  logic [NUM_LANES*Y_W-1:0]   y_i,
  input  logic [NUM_LANES*COL_W-1:0] colour_i,
  input  logic [NUM_LANES-1:0]       wen_i,
  output logic [X_W-1:0]             x_o,
  output logic [Y_W-1:0]             y_o,
  output logic [COL_W-1:0]           colour_o,
  output logic                       wen_o
);

  always_comb begin
    x_o      = '0;
    y_o      = '0;
    colour_o = '0;
    wen_o    = 1'b0;
    if (en_i) begin
      x_o      = x_i[int'(idx_i)*X_W +: X_W];
      y_o      = y_i[int'(idx_i)*Y_W +: Y_W];
      colour_o = colour_i[int'(idx_i)*COL_W +: COL_W];
      wen_o    = wen_i[idx_i];
    end
  end

endmodule

// File: rtl/arrow_draw_scheduler.sv
// Per-frame sequencer: snapshots lane activity on frame_tick, starts each drawable lane's
// drawer in turn, waits for its done, and forwards that drawer's pixels to the VGA port.
module arrow_draw_scheduler
  import arrow_draw_scheduler_pkg::*;
#(
  parameter int LANE_X_BASE = 40,
  parameter int LANE_PITCH  = 20,
  parameter int Y_MAX       = 112
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     frame_tick,
  input  logic [NUM_LANES-1:0]     lane_valid,
  input  logic [NUM_LANES*Y_W-1:0] lane_y,
  arrow_draw_scheduler_if.master   drw,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  state_t                   state_q;
  logic [LANE_IDX_W-1:0]    idx_q;
  logic [NUM_LANES-1:0]     valid_q;
  logic [NUM_LANES*Y_W-1:0] y_q;
  logic [NUM_LANES-1:0]     start_q;
  logic [X_W-1:0]           refx_q;
  logic [Y_W-1:0]           refy_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     overrun_q;

  logic [Y_W-1:0] cur_y;
  logic [X_W-1:0] lane_x;
  logic           lane_ok;
  logic           last_lane;
  logic           pix_en;

  always_comb begin
    cur_y     = y_q[int'(idx_q)*Y_W +: Y_W];
    lane_x    = X_W'(LANE_X_BASE + int'(idx_q) * LANE_PITCH);
    // Lanes below Y_MAX would push the 8-row sprite past the bottom of the screen.
    lane_ok   = valid_q[idx_q] && (int'(cur_y) <= Y_MAX);
    last_lane = (idx_q == LANE_IDX_W'(NUM_LANES - 1));
    pix_en    = (state_q == ST_START) || (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_HIGH);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      valid_q   <= '0;
      y_q       <= '0;
      start_q   <= '0;
      refx_q    <= '0;
      refy_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      start_q <= '0;
      done_q  <= 1'b0;
      if (frame_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            valid_q <= lane_valid;
            y_q     <= lane_y;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (lane_ok) begin
            start_q <= lane_onehot(idx_q);
            refx_q  <= lane_x;
            refy_q  <= cur_y;
            state_q <= ST_START;
          end else if (last_lane) begin
            state_q <= ST_FINISH;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        // done is still high from the drawer's idle state here, so it is not sampled.
        ST_START: state_q <= ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!drw.drw_done[idx_q]) begin
            state_q <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (drw.drw_done[idx_q]) begin
            if (last_lane) begin
              state_q <= ST_FINISH;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign drw.drw_start = start_q;
  assign drw.drw_refX  = refx_q;
  assign drw.drw_refY  = refy_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign overrun       = overrun_q;

  arrow_draw_scheduler_pixel_mux4 u_pixel_mux (
    .en_i     (pix_en),
    .idx_i    (idx_q),
    .x_i      (drw.drw_x),
    .y_i      (drw.drw_y),
    .colour_i (drw.drw_colour),
    .wen_i    (drw.drw_wen),
    .x_o      (drw.x),
    .y_o      (drw.y),
    .colour_o (drw.colour),
    .wen_o    (drw.writeEn)
  );

endmodule

// File: tb/tb_arrow_draw_scheduler.sv
// Scoreboard bench: stimulus pushes expected start/done events, a monitor pops and compares them.
module tb_arrow_draw_scheduler;
  import arrow_draw_scheduler_pkg::*;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  lane_valid = '0;
  logic [27:0] lane_y     = '0;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  arrow_draw_scheduler_if dif ();

  arrow_draw_scheduler #(
    .LANE_X_BASE (40),
    .LANE_PITCH  (20),
    .Y_MAX       (112)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .lane_valid (lane_valid),
    .lane_y     (lane_y),
    .drw        (dif),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // kind 0 = drawer start, kind 1 = frame_done
  typedef struct {
    int kind;
    int lane;
    int refx;
    int refy;
    int cyc;
    int npix;
  } exp_t;
  exp_t q[$];

  task automatic push_start(input int lane, input int refx, input int refy, input int c);
    exp_t e;
    e.kind = 0; e.lane = lane; e.refx = refx; e.refy = refy; e.cyc = c; e.npix = 0;
    q.push_back(e);
  endtask

  task automatic push_done(input int c, input int npix);
    exp_t e;
    e.kind = 1; e.lane = 0; e.refx = 0; e.refy = 0; e.cyc = c; e.npix = npix;
    q.push_back(e);
  endtask

  // Drawer BFMs: drop done after start, emit 64 pixels, then raise done.
  int         bcnt [4];
  logic [7:0] bx [4];
  logic [6:0] by [4];
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        bcnt[i] = 0;
        dif.drw_done[i] = 1'b1;
        dif.drw_wen[i]  = 1'b0;
        dif.drw_x[i*8 +: 8] = '0;
        dif.drw_y[i*7 +: 7] = '0;
        dif.drw_colour[i*3 +: 3] = 3'(i + 1);
      end else if (dif.drw_start[i]) begin
        bcnt[i] = 64;
        bx[i] = dif.drw_refX;
        by[i] = dif.drw_refY;
        dif.drw_done[i] = 1'b0;
        dif.drw_wen[i]  = 1'b0;
      end else if (bcnt[i] > 0) begin
        dif.drw_wen[i] = 1'b1;
        dif.drw_x[i*8 +: 8] = bx[i] + 8'((64 - bcnt[i]) % 8);
        dif.drw_y[i*7 +: 7] = by[i] + 7'((64 - bcnt[i]) / 8);
        bcnt[i] = bcnt[i] - 1;
      end else begin
        dif.drw_wen[i]  = 1'b0;
        dif.drw_done[i] = 1'b1;
      end
    end
  end

  // Monitor
  int cur_lane = 0, cur_refx = 0, cur_refy = 0, pix_lane = 0, pix_frame = 0;
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (!reset_n) begin
      pix_frame = 0;
      pix_lane  = 0;
    end else begin
      if (dif.drw_start != 4'b0) begin
        if (q.size() == 0) begin
          chk("start_unexpected", int'(dif.drw_start), 0);
        end else begin
          e = q.pop_front();
          chk("start_kind", 0, e.kind);
          chk("start_vec", int'(dif.drw_start), 1 << e.lane);
          chk("start_refx", int'(dif.drw_refX), e.refx);
          chk("start_refy", int'(dif.drw_refY), e.refy);
          chk("start_cycle", cyc, e.cyc);
          cur_lane = e.lane; cur_refx = e.refx; cur_refy = e.refy; pix_lane = 0;
        end
      end
      if (dif.writeEn) begin
        chk("pixel_xyc", (int'(dif.x) << 10) | (int'(dif.y) << 3) | int'(dif.colour),
            ((cur_refx + pix_lane % 8) << 10) | ((cur_refy + pix_lane / 8) << 3) | (cur_lane + 1));
        pix_lane++;
        pix_frame++;
      end
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("frame_done_unexpected", int'(frame_done), 0);
        end else begin
          e = q.pop_front();
          chk("done_kind", 1, e.kind);
          chk("done_cycle", cyc, e.cyc);
          chk("done_pixels", pix_frame, e.npix);
        end
        pix_frame = 0;
      end
    end
  end

  task automatic tick(input logic [3:0] v, input logic [27:0] ys, output int t);
    @(negedge clock);
    lane_valid = v;
    lane_y     = ys;
    frame_tick = 1'b1;
    t = cyc;
    @(negedge clock);
    frame_tick = 1'b0;
    lane_valid = 4'b1111;
    lane_y     = '1;
  endtask

  task automatic drain(input string name, input int limit);
    for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clock);
    chk(name, q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  int t;

  initial begin
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_start", int'(dif.drw_start), 0);
    chk("rst_refxy", (int'(dif.drw_refX) << 7) | int'(dif.drw_refY), 0);
    chk("rst_pixel", int'({dif.x, dif.y, dif.colour, dif.writeEn}), 0);

    // Lanes 0 and 2; lane_y is scrambled right after the tick.
    tick(4'b0101, {7'd7, 7'd50, 7'd5, 7'd10}, t);
    chk("busy_t1", int'(busy), 1);
    push_start(0, 40, 10, t + 2);
    push_start(2, 80, 50, t + 70);
    push_done(t + 138, 128);
    drain("drain_0101", 300);
    chk("busy_after_0101", int'(busy), 0);

    // Lane 3 one row past the limit: clipped.
    tick(4'b1000, {7'd113, 7'd0, 7'd0, 7'd0}, t);
    push_done(t + 6, 0);
    drain("drain_clip", 30);

    // Lane 3 exactly at the limit: drawn.
    tick(4'b1000, {7'd112, 7'd0, 7'd0, 7'd0}, t);
    push_start(3, 100, 112, t + 5);
    push_done(t + 72, 64);
    drain("drain_ymax", 150);
    chk("overrun_before", int'(overrun), 0);

    // frame_tick while lane 1 draws.
    tick(4'b0010, {7'd0, 7'd0, 7'd30, 7'd0}, t);
    push_start(1, 60, 30, t + 3);
    push_done(t + 72, 64);
    repeat (20) @(negedge clock);
    frame_tick = 1'b1;
    lane_valid = 4'b1111;
    lane_y     = '0;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    drain("drain_overrun", 150);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset during lane 2 WAIT_HIGH.
    tick(4'b0100, {7'd0, 7'd20, 7'd0, 7'd0}, t);
    push_start(2, 80, 20, t + 4);
    repeat (38) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #2;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_pixel", int'({dif.x, dif.y, dif.colour, dif.writeEn}), 0);
    chk("rstmid_start", int'(dif.drw_start), 0);
    chk("rstmid_refx", int'(dif.drw_refX), 0);
    chk("rstmid_overrun", int'(overrun), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    chk("rstmid_queue", q.size(), 0);
    chk("rstmid_idle_busy", int'(busy), 0);

    // Normal frame after the reset.
    tick(4'b0001, {7'd0, 7'd0, 7'd0, 7'd0}, t);
    push_start(0, 40, 0, t + 2);
    push_done(t + 72, 64);
    drain("drain_post_reset", 150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

endmodule
